// File: rtl/imem_encode_loader.sv
// Encodes symbolic instructions into MIPS words, writes them to instruction memory and appends STOP.
// Define IMEM_CHECKSUM_EN to add a running XOR checksum of every word written.
module imem_encode_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [31:0]       checksum
);

    localparam logic [31:0]       STOP_WORD = 32'hFC00_0000;
    // Last slot is kept for STOP, so the final program word lands at DEPTH-2
    localparam logic [ADDR_W-1:0] CAP_ADDR  = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, LOAD, TERM, DONE} state_t;
    typedef enum logic [1:0] {K_R, K_I, K_J, K_NOP} kind_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       enc;
    logic              legal;
    logic              hs;
    logic              restart;
    logic [5:0]        funct, opc;
    kind_t             kind;

    // Mnemonic -> opcode/funct lookup
    always_comb begin
        funct = 6'd0;
        opc   = 6'd0;
        kind  = K_R;
        legal = 1'b1;
        case (in_op)
            5'd0:  funct = 6'd0;
            5'd1:  funct = 6'd2;
            5'd2:  funct = 6'd3;
            5'd3:  funct = 6'd4;
            5'd4:  funct = 6'd6;
            5'd5:  funct = 6'd7;
            5'd6:  funct = 6'd8;
            5'd7:  funct = 6'd32;
            5'd8:  funct = 6'd33;
            5'd9:  funct = 6'd34;
            5'd10: funct = 6'd35;
            5'd11: funct = 6'd36;
            5'd12: funct = 6'd37;
            5'd13: funct = 6'd38;
            5'd14: funct = 6'd39;
            5'd15: funct = 6'd42;
            5'd16: begin kind = K_I; opc = 6'd4;  end
            5'd17: begin kind = K_I; opc = 6'd5;  end
            5'd18: begin kind = K_I; opc = 6'd8;  end
            5'd19: begin kind = K_I; opc = 6'd9;  end
            5'd20: begin kind = K_I; opc = 6'd12; end
            5'd21: begin kind = K_I; opc = 6'd13; end
            5'd22: begin kind = K_I; opc = 6'd14; end
            5'd23: begin kind = K_I; opc = 6'd35; end
            5'd24: begin kind = K_I; opc = 6'd43; end
            5'd25: begin kind = K_J; opc = 6'd2;  end
            5'd26: begin kind = K_J; opc = 6'd3;  end
            5'd27: kind = K_NOP;
            default: begin kind = K_NOP; legal = 1'b0; end
        endcase
    end

    // Field packing with per-format forced-zero fields
    always_comb begin
        enc = 32'd0;
        case (kind)
            K_R: begin
                if (in_op <= 5'd2)
                    enc = {6'd0, 5'd0, in_rt, in_rd, in_shamt, funct};
                else if (in_op == 5'd6)
                    enc = {6'd0, in_rs, 5'd0, 5'd0, 5'd0, funct};
                else
                    enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, funct};
            end
            K_I:     enc = {opc, in_rs, in_rt, in_imm};
            K_J:     enc = {opc, in_target};
            default: enc = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = (state == LOAD);
        done     = (state == DONE);
        hs       = in_valid && (state == LOAD);
        restart  = start && ((state == IDLE) || (state == DONE));
        case (state)
            IDLE, DONE: if (start) state_nx = LOAD;
            LOAD: if (hs && (in_last || (legal && addr == CAP_ADDR))) state_nx = TERM;
            TERM: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 32'd0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (restart) begin
                addr <= '0;
                err  <= 1'b0;
                ovf  <= 1'b0;
            end else if (hs) begin
                if (legal) begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    wr_data <= enc;
                    addr    <= addr + 1'b1;
                    if (addr == CAP_ADDR && !in_last) ovf <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end else if (state == TERM) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= STOP_WORD;
            end
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] csum;

    // Tracks wr_data exactly, so it is final when done rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                csum <= 32'd0;
        else if (restart)          csum <= 32'd0;
        else if (hs && legal)      csum <= csum ^ enc;
        else if (state == TERM)    csum <= csum ^ STOP_WORD;
    end

    assign checksum = csum;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_encode_loader.sv
// Directed bench: a default-depth loader plus an ADDR_W=2 instance for the capacity case.
module tb_imem_encode_loader;

    logic        clk, rst_n, start, in_valid, in_last;
    logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready, wr_en, done, err, ovf;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data, checksum;

    logic        s_in_ready, s_wr_en, s_done, s_err, s_ovf;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data, s_checksum;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] STOP = 32'hFC00_0000;

    imem_encode_loader #(.ADDR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err), .ovf(ovf),
        .checksum(checksum)
    );

    imem_encode_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_last(in_last), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .wr_en(s_wr_en),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data), .done(s_done), .err(s_err), .ovf(s_ovf),
        .checksum(s_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] d);
        chk({tag, ".wr_en"}, {31'd0, wr_en}, 32'd1);
        chk({tag, ".addr"},  {24'd0, wr_addr}, {24'd0, a});
        chk({tag, ".data"},  wr_data, d);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
        #2;
        chk("rst.wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst.wr_addr", {24'd0, wr_addr}, 32'd0);
        chk("rst.wr_data", wr_data, 32'd0);
        chk("rst.flags", {28'd0, in_ready, done, err, ovf}, 32'd0);
        chk("rst.checksum", checksum, 32'd0);
        rst_n = 1'b1;

        // Single ADD with in_last
        pulse_start();
        chk("s1.ready", {31'd0, in_ready}, 32'd1);
        send(5'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1);
        wr_chk("s1.add", 8'd0, 32'h0022_1820);
        chk("s1.ready_term", {31'd0, in_ready}, 32'd0);
        tick();
        wr_chk("s1.stop", 8'd1, STOP);
        chk("s1.done", {31'd0, done}, 32'd1);
        chk("s1.err", {31'd0, err}, 32'd0);
`ifdef IMEM_CHECKSUM_EN
        chk("s1.checksum", checksum, 32'hFC22_1820);
`else
        chk("s1.checksum", checksum, 32'd0);
`endif
        tick();
        chk("s1.idle_wr_en", {31'd0, wr_en}, 32'd0);
        chk("s1.hold_data", wr_data, STOP);
        chk("s1.done_hold", {31'd0, done}, 32'd1);

        // Back-to-back stream
        pulse_start();
        chk("s2.done_clr", {31'd0, done}, 32'd0);
        send(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1'b0);
        wr_chk("s2.addi", 8'd0, 32'h2008_0005);
        send(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b0);
        wr_chk("s2.j", 8'd1, 32'h0800_0010);
        send(5'd23, 5'd29, 5'd9, 5'd0, 5'd0, 16'hFFFC, 26'd0, 1'b1);
        wr_chk("s2.lw", 8'd2, 32'h8FA9_FFFC);
        tick();
        wr_chk("s2.stop", 8'd3, STOP);
        tick();

        // SLL masking, illegal op mid-stream, JR forcing
        pulse_start();
        send(5'd0, 5'd7, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0, 1'b0);
        wr_chk("s3.sll", 8'd0, 32'h0001_1100);
        send(5'd30, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("s3.ill_wr_en", {31'd0, wr_en}, 32'd0);
        chk("s3.ill_err", {31'd0, err}, 32'd1);
        send(5'd6, 5'd31, 5'd5, 5'd5, 5'd3, 16'd0, 26'd0, 1'b1);
        wr_chk("s3.jr", 8'd1, 32'h03E0_0008);
        tick();
        wr_chk("s3.stop", 8'd2, STOP);
        chk("s3.err_sticky", {31'd0, err}, 32'd1);
        tick();

        // Illegal op carrying in_last: STOP at unadvanced address
        pulse_start();
        chk("s4.err_clr", {31'd0, err}, 32'd0);
        send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
        chk("s4.wr_en", {31'd0, wr_en}, 32'd0);
        chk("s4.err_ready", {30'd0, err, in_ready}, 32'd2);
        tick();
        wr_chk("s4.stop", 8'd0, STOP);
        chk("s4.done", {31'd0, done}, 32'd1);
        tick();

        // Capacity on the ADDR_W=2 instance
        pulse_start();
        send(5'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("cap.a0", {29'd0, s_wr_en, s_wr_addr}, 32'h4);
        send(5'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("cap.a1", {29'd0, s_wr_en, s_wr_addr}, 32'h5);
        send(5'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("cap.a2", {29'd0, s_wr_en, s_wr_addr}, 32'h6);
        chk("cap.d2", s_wr_data, 32'h0022_1820);
        chk("cap.ovf_ready", {30'd0, s_ovf, s_in_ready}, 32'd2);
        send(5'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("cap.stop_addr", {29'd0, s_wr_en, s_wr_addr}, 32'h7);
        chk("cap.stop_data", s_wr_data, STOP);
        chk("cap.done_ovf", {29'd0, s_done, s_ovf, s_in_ready}, 32'd6);
        send(5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
        chk("cap.no_more", {31'd0, s_wr_en}, 32'd0);
        tick();
        tick();

        // Reset mid-load at address 2
        pulse_start();
        send(5'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        send(5'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst2.wr", {23'd0, wr_en, wr_addr}, 32'd0);
        chk("rst2.data", wr_data, 32'd0);
        chk("rst2.flags", {28'd0, in_ready, done, err, ovf}, 32'd0);
        tick();
        tick();
        chk("rst2.no_wr", {30'd0, wr_en, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
